wt_dcache_flush_seq: RTL and testbench
======================================

Name: wt_dcache_flush_seq

Overview:
- Flush/invalidate sequencer for the write-through L1 dcache.
- On a flush request it:
  - blocks new read-controller requests,
  - drains the write buffer and outstanding misses,
  - walks every cache index through the cacheline write port, clearing all valid bits,
  - returns a single-cycle acknowledge.
- Sits between the flush request from the core and the dcache memory's cacheline write port, sharing that port with the miss unit through a grant handshake.

Parameters:
- NumSets, 256, number of cache indices walked; power of two, >=2.
- IdxWidth, 8, index width; equals log2(NumSets).
- SetAssoc, 8, number of ways; width of way-enable and valid-bit vectors.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  flush request; requester holds it high until it sees flush_ack_o.
- flush_ack_o  out  1  single-cycle flush-done pulse.
- busy_o  out  1  high in any state other than IDLE.
- rd_block_o  out  1  stalls read controllers from issuing new misses; high in DRAIN and INV.
- cache_en_i  in  1  cache enable from CSR path.
- wbuffer_empty_i  in  1  write buffer empty.
- miss_pending_i  in  1  miss unit has outstanding transactions.
- wr_cl_vld_o  out  1  cacheline write request.
- wr_cl_ack_i  in  1  grant for the cacheline write port; the write takes effect in the cycle of (vld & ack).
- wr_cl_we_o  out  SetAssoc  way enables; all ones when wr_cl_vld_o is high, else zero.
- wr_cl_idx_o  out  IdxWidth  index being invalidated.
- wr_vld_bits_o  out  SetAssoc  valid bits written; always zero.

Behaviour:
- One clock domain, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state IDLE, index counter 0, all outputs 0.
- States: IDLE, DRAIN, INV, DONE. State is registered; all outputs decode from state and counter, with no combinational path from flush_i.
- IDLE:
  - flush_i=1 -> DRAIN.
- DRAIN:
  - rd_block_o=1.
  - When wbuffer_empty_i=1 and miss_pending_i=0 in the same cycle:
    - cache_en_i=1 -> INV.
    - cache_en_i=0 -> DONE (skip the walk; the array is not consulted while disabled).
  - Otherwise remain in DRAIN indefinitely.
- INV:
  - rd_block_o=1, wr_cl_vld_o=1, wr_cl_idx_o=counter.
  - Counter increments only on wr_cl_ack_i=1.
  - Ack at counter==NumSets-1: counter wraps to 0, go to DONE.
  - No ack: hold vld, idx and we stable.
- DONE:
  - flush_ack_o=1 for exactly one cycle, then IDLE.
- Latency: flush_i sampled in IDLE at cycle 0; if drained and ack is always high, flush_ack_o is asserted at cycle NumSets+2.
- flush_i dropped mid-sequence: ignored; the sequence always completes and acks.
- flush_i high in the cycle after DONE: treated as a new request (IDLE -> DRAIN).
- cache_en_i changing during INV: ignored; the walk completes.
- wbuffer_empty_i falling during INV: ignored; drain is checked only in DRAIN.
- rst_i asserted mid-sequence: returns to IDLE next cycle, counter 0, no ack emitted, wr_cl_vld_o low.

Optional Feature:
- Macro: WT_DCACHE_FLUSH_PERF_EN.
- Defined:
  - Adds output flush_cycles_o [31:0].
  - Counts cycles spent in DRAIN, INV and DONE for the most recent flush.
  - Cleared on the IDLE->DRAIN transition; holds its value in IDLE; saturates at 32'hFFFFFFFF.
  - Reset value 0.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- NumSets=4, wbuffer_empty_i=1, miss_pending_i=0, cache_en_i=1, wr_cl_ack_i=1, pulse flush_i at cycle 0 -> wr_cl_vld_o high cycles 2-5 with idx 0,1,2,3; flush_ack_o=1 only at cycle 6; wr_vld_bits_o=0 and wr_cl_we_o=8'hFF throughout.
- Same setup with wbuffer_empty_i=0 until cycle 10 -> rd_block_o high from cycle 1; first write at cycle 11; ack at cycle 15.
- wr_cl_ack_i low on every other INV cycle -> each idx is held stable until acked; sequence 0..3 with no skips or repeats; ack at cycle 10.
- cache_en_i=0, drained -> no wr_cl_vld_o at all; flush_ack_o at cycle 2.
- rst_i asserted while idx=2 in INV -> next cycle state IDLE, busy_o=0, no flush_ack_o; a new flush_i then restarts from idx 0.
- With WT_DCACHE_FLUSH_PERF_EN, scenario 1 -> flush_cycles_o=6 after the ack, held until the next flush begins.

Source files
------------

// File: rtl/wt_dcache_flush_seq.sv
// -----------------------------------------------------------------------------
// wt_dcache_flush_seq
//
// Flush/invalidate sequencer for the write-through L1 dcache. A flush request
// blocks new read-controller misses, waits for the write buffer and the miss
// unit to drain, walks every cache index through the shared cacheline write
// port to clear all valid bits, and then emits a single-cycle acknowledge.
// If the cache is disabled when the drain completes, the walk is skipped.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   flush_i            flush request, held by the requester until the ack
//   flush_ack_o        one-cycle flush-done pulse
//   busy_o             sequencer is not idle
//   rd_block_o         stall read controllers (DRAIN and INV)
//   cache_en_i         cache enable from the CSR path
//   wbuffer_empty_i    write buffer empty
//   miss_pending_i     miss unit has outstanding transactions
//   wr_cl_vld_o        cacheline write request
//   wr_cl_ack_i        cacheline write port grant; the write lands on vld & ack
//   wr_cl_we_o         way enables (all ways while writing)
//   wr_cl_idx_o        index being invalidated
//   wr_vld_bits_o      valid bits written (always zero)
//   flush_cycles_o     cycles spent in the most recent flush (optional)
//
// Optional feature: define WT_DCACHE_FLUSH_PERF_EN to add flush_cycles_o, a
// saturating count of cycles in DRAIN, INV and DONE for the latest flush.
// -----------------------------------------------------------------------------
module wt_dcache_flush_seq #(
    parameter int unsigned NumSets  = 256,
    parameter int unsigned IdxWidth = 8,
    parameter int unsigned SetAssoc = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    output logic                flush_ack_o,
    output logic                busy_o,
    output logic                rd_block_o,
    input  logic                cache_en_i,
    input  logic                wbuffer_empty_i,
    input  logic                miss_pending_i,
    output logic                wr_cl_vld_o,
    input  logic                wr_cl_ack_i,
    output logic [SetAssoc-1:0] wr_cl_we_o,
    output logic [IdxWidth-1:0] wr_cl_idx_o,
    output logic [SetAssoc-1:0] wr_vld_bits_o
`ifdef WT_DCACHE_FLUSH_PERF_EN
    ,
    output logic [31:0]         flush_cycles_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        INV   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumSets - 1);

    state_e              state_q, state_d;
    logic [IdxWidth-1:0] cnt_q, cnt_d;

    // Next-state and output decode. Outputs depend only on the registered
    // state and index counter, so flush_i never reaches an output directly.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        flush_ack_o   = 1'b0;
        busy_o        = 1'b0;
        rd_block_o    = 1'b0;
        wr_cl_vld_o   = 1'b0;
        wr_cl_we_o    = '0;
        wr_cl_idx_o   = '0;
        wr_vld_bits_o = '0;

        unique case (state_q)
            IDLE: begin
                if (flush_i) state_d = DRAIN;
            end

            DRAIN: begin
                busy_o     = 1'b1;
                rd_block_o = 1'b1;
                // A disabled cache is never looked up, so its contents need
                // no invalidation; go straight to the acknowledge.
                if (wbuffer_empty_i && !miss_pending_i) begin
                    state_d = cache_en_i ? INV : DONE;
                end
            end

            INV: begin
                busy_o      = 1'b1;
                rd_block_o  = 1'b1;
                wr_cl_vld_o = 1'b1;
                wr_cl_we_o  = '1;
                wr_cl_idx_o = cnt_q;
                // Advance only on a granted write; without a grant the request
                // stays put so the miss unit can finish its own write first.
                if (wr_cl_ack_i) begin
                    if (cnt_q == LastIdx) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + IdxWidth'(1);
                    end
                end
            end

            DONE: begin
                busy_o      = 1'b1;
                flush_ack_o = 1'b1;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value, independent of statement order.
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WT_DCACHE_FLUSH_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Restart on the IDLE->DRAIN edge, count every non-idle cycle, and hold
    // the final value in IDLE so software can read it after the ack.
    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE) begin
            if (state_d == DRAIN) perf_d = '0;
        end else if (perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign flush_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_wt_dcache_flush_seq.sv
// -----------------------------------------------------------------------------
// tb_wt_dcache_flush_seq
//
// Self-checking bench for wt_dcache_flush_seq with NumSets=4. Each flush is
// described by per-cycle stimulus tables; a reference model derives the
// expected timeline (drain completion, granted writes, ack cycle) from those
// tables and every output is compared on the falling edge of each cycle.
// -----------------------------------------------------------------------------
module tb_wt_dcache_flush_seq;

    localparam int NSETS = 4;
    localparam int IDXW  = 2;
    localparam int WAYS  = 8;
    localparam int MAXC  = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            flush_ack;
    logic            busy;
    logic            rd_block;
    logic            cache_en;
    logic            wb_empty;
    logic            miss_pend;
    logic            wr_cl_vld;
    logic            wr_cl_ack;
    logic [WAYS-1:0] wr_cl_we;
    logic [IDXW-1:0] wr_cl_idx;
    logic [WAYS-1:0] wr_vld_bits;
`ifdef WT_DCACHE_FLUSH_PERF_EN
    logic [31:0]     flush_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Per-cycle stimulus tables, indexed by cycle relative to the request.
    bit s_flush [MAXC];
    bit s_empty [MAXC];
    bit s_pend  [MAXC];
    bit s_en    [MAXC];
    bit s_ack   [MAXC];

    always #5 clk = ~clk;

    wt_dcache_flush_seq #(
        .NumSets (NSETS),
        .IdxWidth(IDXW),
        .SetAssoc(WAYS)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .flush_ack_o    (flush_ack),
        .busy_o         (busy),
        .rd_block_o     (rd_block),
        .cache_en_i     (cache_en),
        .wbuffer_empty_i(wb_empty),
        .miss_pending_i (miss_pend),
        .wr_cl_vld_o    (wr_cl_vld),
        .wr_cl_ack_i    (wr_cl_ack),
        .wr_cl_we_o     (wr_cl_we),
        .wr_cl_idx_o    (wr_cl_idx),
        .wr_vld_bits_o  (wr_vld_bits)
`ifdef WT_DCACHE_FLUSH_PERF_EN
        ,
        .flush_cycles_o (flush_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clean request: pulse at cycle 0, drained, enabled, always granted.
    task automatic fill_default();
        for (int c = 0; c < MAXC; c++) begin
            s_flush[c] = (c == 0);
            s_empty[c] = 1'b1;
            s_pend[c]  = 1'b0;
            s_en[c]    = 1'b1;
            s_ack[c]   = 1'b1;
        end
    endtask

    // Random request; drain is forced by cycle 20 and grants by cycle 40 so
    // every flush completes well inside the tables.
    task automatic fill_random();
        for (int c = 0; c < MAXC; c++) begin
            s_flush[c] = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            s_empty[c] = (c >= 20) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            s_pend[c]  = (c >= 20) ? 1'b0 : 1'($urandom_range(0, 3) == 0);
            s_en[c]    = 1'($urandom_range(0, 3) != 0);
            s_ack[c]   = (c >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drive(input int c);
        rst       = 1'b0;
        flush     = s_flush[c];
        wb_empty  = s_empty[c];
        miss_pend = s_pend[c];
        cache_en  = s_en[c];
        wr_cl_ack = s_ack[c];
    endtask

    // Plays one flush from the tables; starts with the DUT idle one #1 after
    // a rising edge. ack_seen returns the cycle the DUT pulsed flush_ack_o.
    task automatic run_flush(input string name, output int ack_seen);
        int  td, ti, done, n, exp_idx;
        bit  en, exp_vld, exp_busy, exp_blk, exp_ack;

        // Drain completes in the first cycle with an empty buffer and no miss.
        td = 1;
        while (!(s_empty[td] && !s_pend[td])) td++;
        en = s_en[td];
        if (en) begin
            // Walk ends on the cycle of the NSETS-th granted write.
            n  = 0;
            ti = td;
            while (n < NSETS) begin
                ti++;
                if (s_ack[ti]) n++;
            end
            done = ti + 1;
        end else begin
            done = td + 1;
        end

        ack_seen = -1;
        for (int c = 0; c <= done + 1; c++) begin
            drive(c);
            if (c == done + 1) flush = 1'b0;
            @(negedge clk);
            exp_busy = (c >= 1) && (c <= done);
            exp_blk  = (c >= 1) && (c < done);
            exp_vld  = en && (c > td) && (c < done);
            exp_ack  = (c == done);
            exp_idx  = 0;
            if (exp_vld)
                for (int k = td + 1; k < c; k++) exp_idx += int'(s_ack[k]);
            chk({name, ".busy"},     32'(busy),        32'(exp_busy));
            chk({name, ".rd_block"}, 32'(rd_block),    32'(exp_blk));
            chk({name, ".vld"},      32'(wr_cl_vld),   32'(exp_vld));
            chk({name, ".we"},       32'(wr_cl_we),    exp_vld ? 32'hFF : 32'h0);
            chk({name, ".idx"},      32'(wr_cl_idx),   32'(exp_idx));
            chk({name, ".vbits"},    32'(wr_vld_bits), 32'h0);
            chk({name, ".ack"},      32'(flush_ack),   32'(exp_ack));
`ifdef WT_DCACHE_FLUSH_PERF_EN
            if (c == done + 1) chk({name, ".cycles"}, flush_cycles, 32'(done));
`endif
            if (flush_ack === 1'b1 && ack_seen < 0) ack_seen = c;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
    endtask

    initial begin
        int ack_at;

        rst       = 1'b1;
        flush     = 1'b0;
        wb_empty  = 1'b1;
        miss_pend = 1'b0;
        cache_en  = 1'b1;
        wr_cl_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset.busy",  32'(busy),        32'h0);
        chk("reset.blk",   32'(rd_block),    32'h0);
        chk("reset.vld",   32'(wr_cl_vld),   32'h0);
        chk("reset.ack",   32'(flush_ack),   32'h0);
        chk("reset.we",    32'(wr_cl_we),    32'h0);
        chk("reset.idx",   32'(wr_cl_idx),   32'h0);
        chk("reset.vbits", 32'(wr_vld_bits), 32'h0);
`ifdef WT_DCACHE_FLUSH_PERF_EN
        chk("reset.cycles", flush_cycles, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean flush: writes in cycles 2-5, ack in cycle 6.
        fill_default();
        run_flush("s1", ack_at);
        chk("s1.ack_cycle", 32'(ack_at), 32'd6);

        // Write buffer busy until cycle 10.
        fill_default();
        for (int c = 0; c < 10; c++) s_empty[c] = 1'b0;
        run_flush("s2", ack_at);
        chk("s2.ack_cycle", 32'(ack_at), 32'd15);

        // Grant withheld on every other INV cycle.
        fill_default();
        for (int c = 2; c < MAXC; c++) s_ack[c] = (c % 2 == 1);
        run_flush("s3", ack_at);
        chk("s3.ack_cycle", 32'(ack_at), 32'd10);

        // Cache disabled: no walk.
        fill_default();
        for (int c = 0; c < MAXC; c++) s_en[c] = 1'b0;
        run_flush("s4", ack_at);
        chk("s4.ack_cycle", 32'(ack_at), 32'd2);

        // Reset while idx 2 is being written.
        fill_default();
        for (int c = 0; c <= 4; c++) begin
            drive(c);
            if (c == 4) rst = 1'b1;
            @(negedge clk);
            if (c == 4) begin
                chk("rst.pre_vld", 32'(wr_cl_vld), 32'h1);
                chk("rst.pre_idx", 32'(wr_cl_idx), 32'h2);
            end
            @(posedge clk);
            #1;
        end
        rst   = 1'b0;
        flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst.busy", 32'(busy),      32'h0);
            chk("rst.ack",  32'(flush_ack), 32'h0);
            chk("rst.vld",  32'(wr_cl_vld), 32'h0);
            chk("rst.idx",  32'(wr_cl_idx), 32'h0);
            @(posedge clk);
            #1;
        end
        fill_default();
        run_flush("s5", ack_at);
        chk("s5.ack_cycle", 32'(ack_at), 32'd6);

        // Randomized flushes against the model.
        for (int t = 0; t < 25; t++) begin
            fill_random();
            run_flush($sformatf("rnd%0d", t), ack_at);
            chk($sformatf("rnd%0d.ack_seen", t), 32'(ack_at >= 2), 32'h1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge clk);
                #1;
            end
        end

`ifdef WT_DCACHE_FLUSH_PERF_EN
        // Counter holds in IDLE and restarts with the next flush.
        fill_default();
        run_flush("p1", ack_at);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("perf.hold", flush_cycles, 32'd6);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("perf.clear", flush_cycles, 32'd0);
        repeat (8) @(posedge clk);
        #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
